// File: rtl/stopwatch_counter.sv
// -----------------------------------------------------------------------------
// stopwatch_counter
//
// Purpose:
//   Datapath behind the stopwatch control FSM. A prescaler divides clk down to
//   a centisecond time base. A four-digit BCD counter keeps the running time
//   SS.CC, from 00.00 to 59.99, and then rolls over.
//
// Optional feature (macro STOPWATCH_LAP_EN):
//   When the macro is defined, a lap pulse freezes the displayed time while
//   live counting continues. A second lap pulse releases the freeze.
//   When the macro is undefined, the lap input is ignored and no lap
//   registers exist.
//
// Parameters:
//   CLK_DIV : clk cycles per centisecond tick (2 .. 2^24)
//   CNT_W   : prescaler width, 2^CNT_W >= CLK_DIV
//
// Ports:
//   clk           in   system clock, rising edge
//   reset         in   synchronous, active-low reset
//   init_regs     in   clear time and prescaler (also releases lap freeze)
//   count_enabled in   advance time while high
//   lap           in   single-cycle lap pulse (used only with STOPWATCH_LAP_EN)
//   digits        out  {sec_tens, sec_ones, csec_tens, csec_ones}, BCD
//   tick          out  one-cycle pulse in the cycle a centisecond completes
//   wrap          out  one-cycle pulse in the tick cycle of 59.99 -> 00.00
// -----------------------------------------------------------------------------
module stopwatch_counter #(
   parameter int CLK_DIV = 1000000,
   parameter int CNT_W   = 24
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        init_regs,
   input  logic        count_enabled,
   input  logic        lap,
   output logic [15:0] digits,
   output logic        tick,
   output logic        wrap
);

   localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] presc_q, presc_d;
   logic [3:0]       cs1_q, cs1_d;   // centiseconds, ones
   logic [3:0]       cs10_q, cs10_d; // centiseconds, tens
   logic [3:0]       s1_q, s1_d;     // seconds, ones
   logic [3:0]       s10_q, s10_d;   // seconds, tens
   logic [15:0]      live;

   assign live = {s10_q, s1_q, cs10_q, cs1_q};

   // tick/wrap are combinational so that the consumer samples them on the
   // same edge at which the time advances. Reset and init both mask them.
   assign tick = reset && !init_regs && count_enabled && (presc_q == DIV_LAST);
   assign wrap = tick && (live == 16'h5999);

   always_comb begin
      presc_d = presc_q;
      cs1_d   = cs1_q;
      cs10_d  = cs10_q;
      s1_d    = s1_q;
      s10_d   = s10_q;
      if (init_regs) begin
         presc_d = '0;
         cs1_d   = 4'd0;
         cs10_d  = 4'd0;
         s1_d    = 4'd0;
         s10_d   = 4'd0;
      end else if (count_enabled) begin
         if (presc_q == DIV_LAST) begin
            presc_d = '0;
            // Ripple carry: each digit advances only when all lower digits
            // wrap in the same tick.
            if (cs1_q == 4'd9) begin
               cs1_d = 4'd0;
               if (cs10_q == 4'd9) begin
                  cs10_d = 4'd0;
                  if (s1_q == 4'd9) begin
                     s1_d = 4'd0;
                     if (s10_q == 4'd5) s10_d = 4'd0;
                     else               s10_d = s10_q + 4'd1;
                  end else begin
                     s1_d = s1_q + 4'd1;
                  end
               end else begin
                  cs10_d = cs10_q + 4'd1;
               end
            end else begin
               cs1_d = cs1_q + 4'd1;
            end
         end else begin
            presc_d = presc_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         presc_q <= '0;
         cs1_q   <= 4'd0;
         cs10_q  <= 4'd0;
         s1_q    <= 4'd0;
         s10_q   <= 4'd0;
      end else begin
         presc_q <= presc_d;
         cs1_q   <= cs1_d;
         cs10_q  <= cs10_d;
         s1_q    <= s1_d;
         s10_q   <= s10_d;
      end
   end

`ifdef STOPWATCH_LAP_EN
   logic        frozen_q, frozen_d;
   logic [15:0] lap_q, lap_d;

   // A lap pulse toggles the freeze. Entering the freeze captures the live
   // time as it stands before this edge. init_regs always ends unfrozen.
   always_comb begin
      frozen_d = frozen_q;
      lap_d    = lap_q;
      if (init_regs) begin
         frozen_d = 1'b0;
      end else if (lap) begin
         if (!frozen_q) begin
            frozen_d = 1'b1;
            lap_d    = live;
         end else begin
            frozen_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         frozen_q <= 1'b0;
         lap_q    <= 16'h0000;
      end else begin
         frozen_q <= frozen_d;
         lap_q    <= lap_d;
      end
   end

   assign digits = frozen_q ? lap_q : live;
`else
   // lap is intentionally unused in this build.
   logic unused_lap;
   assign unused_lap = lap;
   assign digits     = live;
`endif

endmodule
